// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: controller state encoding,
// frame geometry, default clock/baud settings and the bit-period calculation.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Transmit controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } tx_state_t;

  localparam int FRAME_BITS   = 10;  // start + 8 data + stop
  localparam int DATA_BITS    = 8;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115200;

  // Number of system clock cycles per line bit (integer division).
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. While enabled it counts 0..CLKS_PER_BIT-1 and wraps;
// o_tick is high for the one cycle in which the count sits at its last value.
// The tick is produced from a flop, so o_tick_nxt (its next value) is offered
// for users that need to register something coincident with the tick.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   i_en       in   count enable
//   i_clr      in   synchronous clear (wins over enable)
//   o_tick     out  one-cycle pulse per bit period (registered)
//   o_tick_nxt out  value o_tick takes after the next edge
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick,
  output logic o_tick_nxt
);

  localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic             tick_q, tick_d;

  // Next count and look-ahead tick
  always_comb begin
    baud_cnt_d = baud_cnt_q;
    tick_d     = 1'b0;
    if (i_clr) begin
      baud_cnt_d = '0;
    end else if (i_en) begin
      if (baud_cnt_q == CNT_MAX) begin
        baud_cnt_d = '0;
      end else begin
        baud_cnt_d = baud_cnt_q + CNT_ONE;
      end
    end else begin
      baud_cnt_d = baud_cnt_q;
    end
    // The tick flop mirrors "counter is at its last value" for the next cycle.
    tick_d = i_en && !i_clr && (baud_cnt_d == CNT_MAX);
  end

  // Counter and tick registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign o_tick     = tick_q;
  assign o_tick_nxt = tick_d;

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// Sequencing controller for the UART transmit path. Accepts a byte over a
// valid/ready handshake, then drives an external shift register with a single
// load pulse followed by one shift_en pulse per bit period for a 10-bit frame
// (start 0, 8 data LSB first, stop 1). All outputs are registered.
// Ports:
//   clk            in   system clock
//   rst_n          in   synchronous active-low reset
//   i_tx_valid     in   requester has a byte
//   i_tx_data[7:0] in   byte, sampled only on accept
//   o_tx_ready     out  controller idle, can accept
//   o_sr_data[7:0] out  captured byte to shift register
//   o_sr_load      out  one-cycle load pulse
//   o_sr_shift_en  out  one-cycle pulse per bit period
//   o_tx_busy      out  frame being loaded or sent
//   o_tx_done      out  one-cycle pulse at end of stop bit
// -----------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_ready,
  output logic [DATA_BITS-1:0] o_sr_data,
  output logic                 o_sr_load,
  output logic                 o_sr_shift_en,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int         CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [3:0] LAST_BIT     = 4'(FRAME_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx_ctrl: CLKS_PER_BIT must be at least 2");
  end

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 load_q, load_d;
  logic                 done_q, done_d;
  logic                 baud_en_s, baud_clr_s;
  logic                 tick_s, tick_nxt_s;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (baud_en_s),
    .i_clr      (baud_clr_s),
    .o_tick     (tick_s),
    .o_tick_nxt (tick_nxt_s)
  );

  // Next-state, capture, bit counting and registered-output look-ahead
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    bit_cnt_d  = bit_cnt_q;
    baud_en_s  = 1'b0;
    baud_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_clr_s = 1'b1;
        if (i_tx_valid && ready_q) begin
          data_d  = i_tx_data;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Counters start fresh so the first bit lasts a full period.
        baud_clr_s = 1'b1;
        bit_cnt_d  = 4'd0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        baud_en_s = 1'b1;
        if (tick_s) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = 4'd0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      default: begin
        baud_clr_s = 1'b1;
        bit_cnt_d  = 4'd0;
        state_d    = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    load_d  = (state_d == ST_LOAD);
    // Done must coincide with the last shift_en; shift_en comes from the
    // baud tick flop, so use the tick look-ahead with the next bit count.
    done_d  = (state_d == ST_SEND) && tick_nxt_s && (bit_cnt_d == LAST_BIT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= 8'h00;
      bit_cnt_q <= 4'd0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      load_q    <= load_d;
      done_q    <= done_d;
    end
  end

  assign o_tx_ready    = ready_q;
  assign o_sr_data     = data_q;
  assign o_sr_load     = load_q;
  assign o_sr_shift_en = tick_s;
  assign o_tx_busy     = busy_q;
  assign o_tx_done     = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Bench for uart_tx_ctrl with a behavioural model of the downstream shift
// register (load {stop,data,start}, shift right filling ones, line = bit 0).
// Stimulus pushes each accepted byte into a queue; a monitor decodes the line
// and compares every frame (bit values and exact bit timing) on each done pulse.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, sr_load, sr_shift_en, tx_busy, tx_done;
  logic [7:0] sr_data;
  logic [9:0] sr_q;
  logic       line;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];

  int load_cnt = 0, shift_cnt = 0, done_cnt = 0;
  int overlap_cnt = 0, excl_cnt = 0, idle_pulse_cnt = 0;

  uart_tx_ctrl #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_tx_valid    (tx_valid),
    .i_tx_data     (tx_data),
    .o_tx_ready    (tx_ready),
    .o_sr_data     (sr_data),
    .o_sr_load     (sr_load),
    .o_sr_shift_en (sr_shift_en),
    .o_tx_busy     (tx_busy),
    .o_tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shift register model sharing rst_n
  always @(posedge clk) begin
    if (!rst_n)           sr_q <= 10'h3FF;
    else if (sr_load)     sr_q <= {1'b1, sr_data, 1'b0};
    else if (sr_shift_en) sr_q <= {1'b1, sr_q[9:1]};
  end
  assign line = sr_q[0];

  function automatic void check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor / scoreboard
  bit         in_frame   = 1'b0;
  bit         after_done = 1'b0;
  int         low_cyc    = 0;
  int         off        = 0;
  int         line_bad   = 0;
  logic [9:0] exp_frame  = 10'h3FF;
  logic [9:0] bits       = 10'h3FF;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame   = 1'b0;
      after_done = 1'b0;
    end else begin
      if (after_done) begin
        check("ready_after_done", tx_ready, 1);
        after_done = 1'b0;
      end
      if (sr_load) load_cnt++;
      if (sr_shift_en) shift_cnt++;
      if (sr_load && sr_shift_en) overlap_cnt++;
      if (tx_ready && tx_busy) excl_cnt++;
      if (tx_ready && (sr_load || sr_shift_en)) idle_pulse_cnt++;

      if (!in_frame && line === 1'b0) begin
        in_frame = 1'b1;
        low_cyc  = cyc;
        line_bad = 0;
        check("frame_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) exp_frame = {1'b1, exp_q[0], 1'b0};
        else                   exp_frame = 10'h3FF;
      end
      if (in_frame) begin
        off = cyc - low_cyc;
        if (off < 100) begin
          if (line !== exp_frame[off/10]) line_bad++;
          if (off % 10 == 5) bits[off/10] = line;
        end
      end
      if (tx_done) begin
        done_cnt++;
        check("done_in_frame", int'(in_frame), 1);
        if (in_frame) begin
          check("done_offset", off, 99);
          check("line_bit_timing", line_bad, 0);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check("frame_data", int'(bits[8:1]), int'(exp_b));
            check("start_stop", int'({bits[9], bits[0]}), 2);
          end
          in_frame   = 1'b0;
          after_done = 1'b1;
        end
      end
    end
  end

  // Offer a byte, wait for acceptance; returns just after the accept edge.
  task automatic send(input logic [7:0] b, input bit hold, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    @(posedge clk); #2;
    tx_valid = 1'b1;
    tx_data  = b;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin
        ok  = 1'b1;
        acc = cyc + 1;
        exp_q.push_back(b);
        break;
      end
    end
    if (!ok) check("accept_timeout", tx_ready, 1);
    @(posedge clk); #2;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_ready_timeout", tx_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, l0, s0, d0, bad;

    // 1: reset state and idle line
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_load", sr_load, 0);
    check("rst_shift", sr_shift_en, 0);
    check("rst_done", tx_done, 0);
    check("rst_sr_data", sr_data, 8'h00);
    check("rst_line", line, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || sr_load !== 1'b0 ||
          sr_shift_en !== 1'b0 || tx_done !== 1'b0 || line !== 1'b1) bad++;
    end
    check("idle_50", bad, 0);

    // 2: single byte, handshake latency
    send(8'hA5, 1'b0, acc);
    @(negedge clk);
    check("t2_cycle", cyc, acc);
    check("t2_load_pulse", sr_load, 1);
    check("t2_busy", tx_busy, 1);
    check("t2_ready_low", tx_ready, 0);
    check("t2_sr_data", sr_data, 8'hA5);
    check("t2_line_high_after_e0", line, 1);
    @(negedge clk);
    check("t2_load_one_cycle", sr_load, 0);
    check("t2_line_low_after_e1", line, 0);
    wait_ready();

    // 3: back-to-back with valid held
    send(8'h00, 1'b1, acc);
    send(8'hFF, 1'b0, acc2);
    check("t3_spacing", acc2 - acc, 102);
    wait_ready();

    // 4: valid during SEND ignored, data change after accept ignored
    l0 = load_cnt;
    send(8'h5A, 1'b0, acc);
    @(posedge clk); #2;
    tx_data = 8'hC3;
    repeat (30) @(posedge clk);
    #2;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(posedge clk); #2;
    tx_valid = 1'b0;
    @(negedge clk);
    check("t4_sr_data_held", sr_data, 8'h5A);
    wait_ready();
    repeat (3) @(negedge clk);
    check("t4_single_load", load_cnt - l0, 1);

    // 5: reset in the middle of a frame
    d0 = done_cnt;
    send(8'hC3, 1'b0, acc);
    repeat (42) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_line_high", line, 1);
    check("t5_ready", tx_ready, 1);
    check("t5_busy", tx_busy, 0);
    check("t5_sr_data_reset", sr_data, 8'h00);
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_done", done_cnt - d0, 0);
    send(8'h96, 1'b0, acc);
    wait_ready();
    check("t5_post_reset_data", sr_data, 8'h96);

    // 6: pulse counts over three frames
    l0 = load_cnt;
    s0 = shift_cnt;
    d0 = done_cnt;
    send(8'h11, 1'b0, acc);
    send(8'h22, 1'b0, acc);
    send(8'h33, 1'b0, acc);
    wait_ready();
    repeat (3) @(negedge clk);
    check("t6_loads", load_cnt - l0, 3);
    check("t6_shifts", shift_cnt - s0, 30);
    check("t6_dones", done_cnt - d0, 3);

    // Whole-run invariants
    check("no_load_shift_overlap", overlap_cnt, 0);
    check("ready_busy_exclusive", excl_cnt, 0);
    check("no_pulse_in_idle", idle_pulse_cnt, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
